// File: rtl/rgb_para_ycbcr422_if.sv
// Pixel-in / 4:2:2-byte-out bus for the RGB to YCbCr transmit block.
// The master drives pixels and byte_ready; the slave converts and streams bytes.
interface rgb_para_ycbcr422_if #(
    parameter int unsigned CNT_W = 16
);
    logic             frame_start;
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       R;
    logic [7:0]       G;
    logic [7:0]       B;
    logic [7:0]       byte_out;
    logic             byte_valid;
    logic             byte_ready;
    logic             e_pix;
    logic [CNT_W-1:0] pairs_sent;

    modport master (
        output frame_start, pix_valid, R, G, B, byte_ready,
        input  pix_ready, byte_out, byte_valid, e_pix, pairs_sent
    );

    modport slave (
        input  frame_start, pix_valid, R, G, B, byte_ready,
        output pix_ready, byte_out, byte_valid, e_pix, pairs_sent
    );
endinterface

// File: rtl/rgb_para_ycbcr422.sv
// RGB888 to BT.601 full-range YCbCr, packed per pixel pair as a Cb Y0 Cr Y1
// byte stream with averaged chroma.
module rgb_para_ycbcr422 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 PCLK,
    input  logic                 rst_n,
    rgb_para_ycbcr422_if.slave   bus
);
    localparam logic [2:0] P0    = 3'd0;
    localparam logic [2:0] P1    = 3'd1;
    localparam logic [2:0] TX_CB = 3'd2;
    localparam logic [2:0] TX_Y0 = 3'd3;
    localparam logic [2:0] TX_CR = 3'd4;
    localparam logic [2:0] TX_Y1 = 3'd5;

    logic [2:0]       state_q,      state_d;
    logic [7:0]       y0_q,         y0_d;
    logic [7:0]       y1_q,         y1_d;
    logic [7:0]       cb_q,         cb_d;
    logic [7:0]       cr_q,         cr_d;
    logic             pix_ready_q,  pix_ready_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_out_q,   byte_out_d;
    logic             e_pix_q,      e_pix_d;
    logic [CNT_W-1:0] pairs_sent_q, pairs_sent_d;

    logic signed [17:0] r_s, g_s, b_s;
    logic signed [17:0] y_acc, cb_acc, cr_acc;
    logic [7:0]         y_pix, cb_pix, cr_pix;
    logic [8:0]         cb_sum, cr_sum;
    logic               accept;

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        if (v < 18'sd0)        sat8 = 8'd0;
        else if (v > 18'sd255) sat8 = 8'd255;
        else                   sat8 = v[7:0];
    endfunction

    // Per-pixel colour conversion; arithmetic shifts floor toward -inf
    always_comb begin
        r_s    = signed'(18'(bus.R));
        g_s    = signed'(18'(bus.G));
        b_s    = signed'(18'(bus.B));
        y_acc  = 18'sd77  * r_s + 18'sd150 * g_s + 18'sd29  * b_s;
        cb_acc = 18'sd128 * b_s - 18'sd43  * r_s - 18'sd85  * g_s;
        cr_acc = 18'sd128 * r_s - 18'sd107 * g_s - 18'sd21  * b_s;
        y_pix  = sat8(y_acc >>> 8);
        cb_pix = sat8((cb_acc >>> 8) + 18'sd128);
        cr_pix = sat8((cr_acc >>> 8) + 18'sd128);
        cb_sum = 9'(cb_q) + 9'(cb_pix);
        cr_sum = 9'(cr_q) + 9'(cr_pix);
    end

    always_comb begin
        state_d      = state_q;
        y0_d         = y0_q;
        y1_d         = y1_q;
        cb_d         = cb_q;
        cr_d         = cr_q;
        e_pix_d      = 1'b0;
        pairs_sent_d = pairs_sent_q;
        byte_out_d   = 8'd0;
        accept       = bus.pix_valid & pix_ready_q;

        case (state_q)
            P0: begin
                if (accept) begin
                    y0_d    = y_pix;
                    cb_d    = cb_pix;
                    cr_d    = cr_pix;
                    state_d = P1;
                end
            end
            P1: begin
                // A frame re-align drops the pending pixel and any pixel offered with it
                if (bus.frame_start) begin
                    state_d = P0;
                end else if (accept) begin
                    y1_d    = y_pix;
                    cb_d    = cb_sum[8:1];
                    cr_d    = cr_sum[8:1];
                    state_d = TX_CB;
                end
            end
            TX_CB: if (bus.byte_ready) state_d = TX_Y0;
            TX_Y0: if (bus.byte_ready) state_d = TX_CR;
            TX_CR: if (bus.byte_ready) state_d = TX_Y1;
            TX_Y1: begin
                if (bus.byte_ready) begin
                    state_d      = P0;
                    e_pix_d      = 1'b1;
                    pairs_sent_d = pairs_sent_q + CNT_W'(1);
                end
            end
            default: state_d = P0;
        endcase

        pix_ready_d  = (state_d == P0) || (state_d == P1);
        byte_valid_d = ~pix_ready_d;

        case (state_d)
            TX_CB:   byte_out_d = cb_d;
            TX_Y0:   byte_out_d = y0_d;
            TX_CR:   byte_out_d = cr_d;
            TX_Y1:   byte_out_d = y1_d;
            default: byte_out_d = 8'd0;
        endcase
    end

    always_ff @(posedge PCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= P0;
            y0_q         <= 8'd0;
            y1_q         <= 8'd0;
            cb_q         <= 8'd0;
            cr_q         <= 8'd0;
            pix_ready_q  <= 1'b1;
            byte_valid_q <= 1'b0;
            byte_out_q   <= 8'd0;
            e_pix_q      <= 1'b0;
            pairs_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            y0_q         <= y0_d;
            y1_q         <= y1_d;
            cb_q         <= cb_d;
            cr_q         <= cr_d;
            pix_ready_q  <= pix_ready_d;
            byte_valid_q <= byte_valid_d;
            byte_out_q   <= byte_out_d;
            e_pix_q      <= e_pix_d;
            pairs_sent_q <= pairs_sent_d;
        end
    end

    assign bus.pix_ready  = pix_ready_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_out   = byte_out_q;
    assign bus.e_pix      = e_pix_q;
    assign bus.pairs_sent = pairs_sent_q;

endmodule

// File: tb/tb_rgb_para_ycbcr422.sv
// Bench for rgb_para_ycbcr422: directed pairs plus random pixels and stalls,
// checked every cycle against a pair-level reference model.
module tb_rgb_para_ycbcr422;
    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rgb_para_ycbcr422_if #(.CNT_W(CNT_W)) bus();
    rgb_para_ycbcr422 #(.CNT_W(CNT_W)) dut (.PCLK(clk), .rst_n(rst_n), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic void conv(input int r, input int g, input int b,
                                 output int y, output int cb, output int cr);
        y  = clamp((77 * r + 150 * g + 29 * b) >>> 8);
        cb = clamp(((-43 * r - 85 * g + 128 * b) >>> 8) + 128);
        cr = clamp(((128 * r - 107 * g - 21 * b) >>> 8) + 128);
    endfunction

    // Bytes of one pair, most significant byte is sent first
    function automatic logic [31:0] pair_word(input int r0, input int g0, input int b0,
                                              input int r1, input int g1, input int b1);
        int y0, cb0, cr0, y1, cb1, cr1;
        conv(r0, g0, b0, y0, cb0, cr0);
        conv(r1, g1, b1, y1, cb1, cr1);
        return {8'((cb0 + cb1) / 2), 8'(y0), 8'((cr0 + cr1) / 2), 8'(y1)};
    endfunction

    // Reference model state
    int         exp_q[$];
    int         got[$];
    bit         pend = 1'b0;
    int         pr, pg, pb;
    int         exp_pairs = 0;
    bit         exp_e = 1'b0;
    int         e_cnt = 0;

    // Checks current outputs, then applies the handshakes of the coming edge
    always @(negedge clk) begin
        logic [31:0] w;
        if (!rst_n) begin
            chk("rst_pix_ready",  int'(bus.pix_ready),  1);
            chk("rst_byte_valid", int'(bus.byte_valid), 0);
            chk("rst_byte_out",   int'(bus.byte_out),   0);
            chk("rst_e_pix",      int'(bus.e_pix),      0);
            chk("rst_pairs_sent", int'(bus.pairs_sent), 0);
            exp_q.delete();
            pend      = 1'b0;
            exp_pairs = 0;
            exp_e     = 1'b0;
        end else begin
            chk("pix_ready",  int'(bus.pix_ready),  int'(exp_q.size() == 0));
            chk("byte_valid", int'(bus.byte_valid), int'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("byte_out", int'(bus.byte_out), exp_q[0]);
            chk("e_pix",      int'(bus.e_pix),      int'(exp_e));
            chk("pairs_sent", int'(bus.pairs_sent), exp_pairs);
            if (bus.e_pix) e_cnt++;
            exp_e = 1'b0;
            if (exp_q.size() != 0) begin
                if (bus.byte_ready) begin
                    got.push_back(int'(bus.byte_out));
                    if (exp_q.size() == 1) begin
                        exp_e     = 1'b1;
                        exp_pairs = (exp_pairs + 1) & ((1 << CNT_W) - 1);
                    end
                    void'(exp_q.pop_front());
                end
            end else if (pend && bus.frame_start) begin
                pend = 1'b0;
            end else if (bus.pix_valid) begin
                if (!pend) begin
                    pr = int'(bus.R); pg = int'(bus.G); pb = int'(bus.B);
                    pend = 1'b1;
                end else begin
                    w = pair_word(pr, pg, pb, int'(bus.R), int'(bus.G), int'(bus.B));
                    for (int i = 0; i < 4; i++) exp_q.push_back(int'(w[31-8*i -: 8]));
                    pend = 1'b0;
                end
            end
        end
    end

    // byte_ready source: 0 = always, 1 = random, 2 = manual
    int   rdy_mode = 0;
    logic manual_rdy = 1'b1;
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.byte_ready = 1'b1;
            1:       bus.byte_ready = ($urandom_range(0, 3) != 0);
            default: bus.byte_ready = manual_rdy;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int g, input int b);
        int n = 0;
        bus.R = 8'(r); bus.G = 8'(g); bus.B = 8'(b);
        bus.pix_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.pix_ready) break;
            n++;
            if (n > 200) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: pix_ready stuck at 0, expected 1");
                break;
            end
        end
        tick();
        bus.pix_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.pix_ready && !bus.byte_valid) break;
            n++;
            if (n > 500) begin
                n_cmp++; n_err++;
                $display("FAIL idle_timeout: byte_valid stuck at 1, expected 0");
                break;
            end
        end
        tick();
    endtask

    task automatic chk_pair(input string name, input logic [31:0] w);
        chk({name, "_len"}, got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk(name, (got.size() > i) ? got[i] : -1, int'(w[31-8*i -: 8]));
    endtask

    initial begin
        int y, cb, cr;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Model pinned to hand-computed values
        conv(0, 0, 255, y, cb, cr);
        chk("model_blue_y", y, 28);
        chk("model_blue_cb", cb, 255);
        chk("model_blue_cr", cr, 107);
        chk("model_red_green", int'(pair_word(255, 0, 0, 0, 255, 0) == 32'h404C8A95), 1);

        // Black/white pair
        got.delete(); e_cnt = 0;
        send(0, 0, 0); send(255, 255, 255);
        wait_idle();
        chk_pair("black_white", 32'h800080FF);
        chk("bw_e_pix_pulses", e_cnt, 1);
        chk("bw_pairs_sent", int'(bus.pairs_sent), 1);

        // Red/green, then blue/blue
        got.delete();
        send(255, 0, 0); send(0, 255, 0);
        wait_idle();
        chk_pair("red_green", 32'h404C8A95);
        got.delete();
        send(0, 0, 255); send(0, 0, 255);
        wait_idle();
        chk_pair("blue_blue", 32'hFF1C6B1C);

        // Five-cycle stall in TX_CR
        got.delete();
        rdy_mode = 2; manual_rdy = 1'b0;
        send(255, 0, 0); send(0, 255, 0);
        manual_rdy = 1'b1;
        tick(); tick();
        manual_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_byte_out", int'(bus.byte_out), 138);
            chk("stall_byte_valid", int'(bus.byte_valid), 1);
            chk("stall_pix_ready", int'(bus.pix_ready), 0);
        end
        tick();
        manual_rdy = 1'b1;
        wait_idle();
        chk_pair("stall_pair", 32'h404C8A95);
        rdy_mode = 0;

        // frame_start in P1 with a pixel offered: both dropped
        got.delete();
        send(10, 20, 30);
        bus.frame_start = 1'b1;
        bus.R = 8'd200; bus.G = 8'd100; bus.B = 8'd50;
        bus.pix_valid = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.pix_valid = 1'b0;
        send(1, 2, 3); send(250, 240, 230);
        wait_idle();
        chk_pair("realign", pair_word(1, 2, 3, 250, 240, 230));

        // Reset during TX_Y0
        rdy_mode = 2; manual_rdy = 1'b0;
        send(40, 80, 120); send(120, 80, 40);
        manual_rdy = 1'b1;
        tick();
        manual_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pix_ready",  int'(bus.pix_ready),  1);
        chk("async_rst_byte_valid", int'(bus.byte_valid), 0);
        chk("async_rst_byte_out",   int'(bus.byte_out),   0);
        chk("async_rst_pairs_sent", int'(bus.pairs_sent), 0);
        tick(); tick();
        rst_n = 1'b1;
        rdy_mode = 0;
        got.delete();
        send(30, 60, 90); send(90, 60, 30);
        wait_idle();
        chk_pair("after_reset", pair_word(30, 60, 90, 90, 60, 30));
        chk("after_reset_pairs", int'(bus.pairs_sent), 1);

        // 16 more pairs: counter wraps to 1 after 17
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) begin
            send_rand();
            repeat ($urandom_range(0, 2)) tick();
            send_rand();
        end
        wait_idle();
        chk("wrap_pairs_sent", int'(bus.pairs_sent), 1);

        // Random soak with stalls, gaps and stray frame_start pulses
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.frame_start = 1'b1;
                bus.pix_valid = 1'($urandom_range(0, 1));
                bus.R = 8'($urandom_range(0, 255));
                bus.G = 8'($urandom_range(0, 255));
                bus.B = 8'($urandom_range(0, 255));
                tick();
                bus.frame_start = 1'b0;
                bus.pix_valid = 1'b0;
            end else begin
                send_rand();
            end
            repeat ($urandom_range(0, 1)) tick();
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
